raster_fb_writer: RTL
=====================

Name: raster_fb_writer

Overview:
- Pixel sink directly downstream of the rasterizer's line generator; owns the double-buffered frame memory write port.
- Per frame:
  - clears the back buffer to the background colour;
  - accepts rasterized pixel writes and converts (x,y) to a linear address;
  - drops off-screen pixels;
  - swaps front/back buffers on the next display vsync after raster completion.
- Its frame_ready output gates the line generator's pixel emission.

Parameters:
- H_RES, 640, horizontal resolution in pixels
- V_RES, 480, vertical resolution in lines
- ADDR_W, 19, linear pixel address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- frame_start  in  1  one-cycle pulse, start of a new frame
- bk_color  in  3  background colour used for clear
- px_valid  in  1  pixel write strobe from line generator
- px_x  in  10  pixel x
- px_y  in  9  pixel y
- px_color  in  3  pixel colour
- raster_done  in  1  one-cycle pulse, all pixels of frame emitted
- vsync  in  1  one-cycle pulse from display timing
- frame_ready  out  1  pixels accepted this cycle
- mem_we  out  1  frame memory write enable
- mem_addr  out  ADDR_W+1  {buffer select, linear address}
- mem_wdata  out  3  write colour
- disp_buf  out  1  buffer currently scanned by display
- drop_cnt  out  8  saturating count of off-screen pixels, cleared at frame_start acceptance

Behaviour:
- Reset values: all outputs 0; state IDLE; draw buffer = 1, so draw buffer = ~disp_buf always.
- IDLE:
  - frame_ready=0.
  - On frame_start: latch bk_color, clear drop_cnt, clear_addr=0, go CLEAR.
  - Other inputs ignored.
- CLEAR:
  - frame_ready=0.
  - Each cycle: mem_we=1, mem_addr={~disp_buf, clear_addr}, mem_wdata=latched bk_color; clear_addr increments.
  - After writing address H_RES*V_RES-1, go DRAW on the next cycle.
  - Clear takes exactly H_RES*V_RES cycles.
  - frame_start, px_valid and raster_done are ignored.
- DRAW:
  - frame_ready=1.
  - Pixel accepted when px_valid && frame_ready.
  - 1-cycle write latency: registered stage computes px_y*H_RES+px_x (ADDR_W bits). mem_we=1 the cycle after acceptance with mem_addr={~disp_buf, addr} and mem_wdata=px_color.
  - Back-to-back pixels produce one write per cycle.
  - Off-screen pixel (px_x>=H_RES or px_y>=V_RES): no write; drop_cnt increments, saturating at 255.
  - On raster_done: frame_ready drops the next cycle, go FLUSH.
  - A pixel accepted in the same cycle as raster_done is still written.
  - frame_start ignored.
- FLUSH:
  - One cycle; frame_ready=0.
  - The final pipelined write issues here if pending; go WAIT_SWAP.
- WAIT_SWAP:
  - frame_ready=0, mem_we=0.
  - vsync is sampled only in this state; vsync in any other state has no effect.
  - On vsync: disp_buf toggles the next cycle; go IDLE.
- frame_start arriving in WAIT_SWAP is lost; the upstream frame controller must not issue it before swap.
- mem_we is never asserted in IDLE or WAIT_SWAP.
- Async reset mid-frame: immediate return to reset values; any partial clear or draw is abandoned, and disp_buf returns to 0.
- Arithmetic: multiply is H_RES constant times 9-bit y, truncated to ADDR_W; no overflow for in-range pixels.

Test Plan:
1. Reset, H_RES=8, V_RES=4, ADDR_W=5 -> frame_start with bk_color=3'b101 -> 32 consecutive writes of data 5 at addr {1,0..31}, frame_ready=0 throughout, frame_ready=1 the cycle after the addr-31 write.
2. In DRAW, px_valid on 3 consecutive cycles at (1,0),(7,3),(0,2) colour 2,4,6 -> writes one cycle later at addr {1,1},{1,31},{1,16} with data 2,4,6, back-to-back.
3. Off-screen pixels (8,0) and (0,4) with 300 further off-screen pixels -> no mem_we; drop_cnt saturates at 255; next frame_start clears drop_cnt to 0.
4. px_valid at (2,1) colour 7 in the same cycle as raster_done -> write {1,10}=7 issued; frame_ready low the next cycle; no further writes.
5. vsync pulsed during DRAW, then raster_done, then vsync 5 cycles later -> disp_buf stays 0 until the second vsync and becomes 1 the following cycle; the next frame's clear targets buffer 0.
6. Async reset asserted mid-CLEAR at addr 12 -> mem_we, frame_ready, disp_buf, drop_cnt drop to 0 immediately; after release, idle until frame_start.

Source files
------------

// File: rtl/raster_fb_writer.sv
// raster_fb_writer: clears the back buffer, writes rasterized pixels into it,
// and swaps front/back buffers on the first vsync after raster completion.
module raster_fb_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [2:0]        bk_color,
  input  logic              px_valid,
  input  logic [9:0]        px_x,
  input  logic [8:0]        px_y,
  input  logic [2:0]        px_color,
  input  logic              raster_done,
  input  logic              vsync,
  output logic              frame_ready,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [2:0]        mem_wdata,
  output logic              disp_buf,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] HRES_A = ADDR_W'(H_RES);
  localparam logic [9:0]        HX     = 10'(H_RES);
  localparam logic [8:0]        VY     = 9'(V_RES);

  typedef enum logic [2:0] {
    IDLE, CLEAR, DRAW, FLUSH, WAIT_SWAP
  } state_t;

  state_t            state;
  logic [2:0]        bk;
  logic [ADDR_W-1:0] clear_addr;
  logic [ADDR_W-1:0] clear_nxt;
  logic [ADDR_W-1:0] lin;
  logic              on_screen;

  // Linear pixel address and on-screen test for the incoming pixel
  always_comb begin
    clear_nxt = clear_addr + ADDR_W'(1);
    lin       = ADDR_W'(px_y) * HRES_A + ADDR_W'(px_x);
    on_screen = (px_x < HX) && (px_y < VY);
  end

  // Frame sequencer; all outputs are registered, writes target ~disp_buf
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bk          <= 3'd0;
      clear_addr  <= '0;
      frame_ready <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 3'd0;
      disp_buf    <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            bk         <= bk_color;
            drop_cnt   <= 8'd0;
            clear_addr <= '0;
            mem_we     <= 1'b1;
            mem_addr   <= {~disp_buf, {ADDR_W{1'b0}}};
            mem_wdata  <= bk_color;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          if (clear_addr == LAST) begin
            frame_ready <= 1'b1;
            state       <= DRAW;
          end else begin
            clear_addr <= clear_nxt;
            mem_we     <= 1'b1;
            mem_addr   <= {~disp_buf, clear_nxt};
            mem_wdata  <= bk;
          end
        end
        DRAW: begin
          if (px_valid && frame_ready) begin
            if (on_screen) begin
              mem_we    <= 1'b1;
              mem_addr  <= {~disp_buf, lin};
              mem_wdata <= px_color;
            end else if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
          end
          if (raster_done) begin
            frame_ready <= 1'b0;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (vsync) begin
            disp_buf <= ~disp_buf;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
